router_output_arbiter: RTL and testbench
========================================

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of channel links sharing one output link (legal range 1..16).
REQ-002 SHALL have parameter WORD_WIDTH, default 32, width of the data word carried per transfer.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of the transfer counter.
REQ-004 SHALL define TAG_WIDTH = max(1, clog2(NUM_REQUESTERS)) as a derived localparam.
REQ-005 SHALL have port: clock  input  1  single clock; all state updates on the positive edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port: enable  input  1  active high; low blocks new grants.
REQ-008 SHALL have port: requester_mask  input  NUM_REQUESTERS  bit i high makes requester i eligible.
REQ-009 SHALL have port: in_valid  input  NUM_REQUESTERS  requester i presents a word.
REQ-010 SHALL have port: in_data  input  NUM_REQUESTERS x WORD_WIDTH  word from requester i.
REQ-011 SHALL have port: in_ready  output  NUM_REQUESTERS  requester i's word accepted this cycle.
REQ-012 SHALL have port: out_valid  output  1  output register holds a word.
REQ-013 SHALL have port: out_data  output  WORD_WIDTH  registered word.
REQ-014 SHALL have port: out_tag  output  TAG_WIDTH  index of requester that sourced out_data.
REQ-015 SHALL have port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-016 SHALL have port: transfer_count  output  COUNT_WIDTH  number of completed output transfers.
REQ-017 SHALL have port: quiescent  output  1  high when no word is held.

Function
REQ-018 SHALL complete a transfer on any side when valid and ready are both high in the same cycle; no other condition transfers.
REQ-019 SHALL define eligible[i] = in_valid[i] & requester_mask[i].
REQ-020 SHALL define load = enable & (~out_valid | out_ready) & (|eligible).
REQ-021 SHALL select grant g as the first eligible index found searching cyclically from round-robin pointer rr_ptr upward (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
REQ-022 SHALL drive in_ready[g] = load and all other in_ready bits low (combinational; at most one bit high per cycle).
REQ-023 SHALL, on load, register out_data <= in_data[g], out_tag <= g, out_valid <= 1, rr_ptr <= (g+1) mod NUM_REQUESTERS.
REQ-024 SHALL, when out_valid & out_ready & ~load, clear out_valid; out_data and out_tag hold their last values.
REQ-025 SHALL hold out_valid, out_data, out_tag stable while out_valid & ~out_ready.
REQ-026 SHALL give 1-cycle latency from input acceptance to out_valid, and sustain one transfer per cycle when out_ready stays high (simultaneous drain and refill).
REQ-027 SHALL increment transfer_count on each out_valid & out_ready cycle, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-028 SHALL leave rr_ptr unchanged in cycles without load.
REQ-029 SHALL, with enable low, force all in_ready low while still presenting and draining any held word.
REQ-030 SHALL apply requester_mask changes to the current cycle's arbitration only; a held word is never revoked by masking.
REQ-031 SHALL drive quiescent = ~out_valid.
REQ-032 SHALL, with NUM_REQUESTERS = 1, grant requester 0 whenever load and keep rr_ptr at 0.

Reset
REQ-033 SHALL, on a clock edge with reset low, set out_valid 0, out_data 0, out_tag 0, rr_ptr 0, transfer_count 0, regardless of enable or in-flight handshakes.
REQ-034 SHALL drive in_ready all low during any cycle with reset low, and quiescent 1 from the first post-reset cycle.
REQ-035 SHALL discard any held, untransferred word on reset without counting it.

Verification
REQ-036 SHALL test fairness: N=4, all in_valid high, mask 4'hF, out_ready high -> out_tag sequence 0,1,2,3,0,... one word per cycle, transfer_count +1 each cycle.
REQ-037 SHALL test backpressure: one word loaded, out_ready low 5 cycles -> out_valid/out_data/out_tag stable, in_ready all 0, count unchanged; out_ready high -> count +1.
REQ-038 SHALL test masking and wrap: rr_ptr=3, in_valid=4'b1011, mask=4'b0011 -> grant 0, rr_ptr becomes 1; next grant 1.
REQ-039 SHALL test enable: enable low with held word and requests pending -> held word drains, in_ready stays 0, quiescent rises to 1 after drain.
REQ-040 SHALL test counter wrap: COUNT_WIDTH=4, 17 transfers -> transfer_count reads 1.
REQ-041 SHALL test mid-operation reset: reset low while out_valid=1 and out_ready=0 -> next cycle out_valid 0, count 0, rr_ptr 0, quiescent 1.

Source files
------------

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin merge of several valid/ready channel links
// onto one registered output link, with a completed-transfer counter.
module router_output_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 4,
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned COUNT_WIDTH    = 16,
   localparam int unsigned TAG_WIDTH     = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic [NUM_REQUESTERS-1:0]            requester_mask,
   input  logic [NUM_REQUESTERS-1:0]            in_valid,
   input  logic [NUM_REQUESTERS*WORD_WIDTH-1:0] in_data,
   output logic [NUM_REQUESTERS-1:0]            in_ready,
   output logic                                 out_valid,
   output logic [WORD_WIDTH-1:0]                out_data,
   output logic [TAG_WIDTH-1:0]                 out_tag,
   input  logic                                 out_ready,
   output logic [COUNT_WIDTH-1:0]               transfer_count,
   output logic                                 quiescent
);

   logic [NUM_REQUESTERS-1:0] eligible;
   logic [TAG_WIDTH-1:0]      rr_ptr;
   logic [TAG_WIDTH-1:0]      grant;
   logic [TAG_WIDTH-1:0]      grant_hi;
   logic [TAG_WIDTH-1:0]      grant_lo;
   logic                      found_hi;
   logic [TAG_WIDTH-1:0]      next_ptr;
   logic [WORD_WIDTH-1:0]     sel_data;
   logic                      load;
   logic                      drain;

   assign eligible  = in_valid & requester_mask;
   assign drain     = out_valid & out_ready;
   assign load      = enable & (~out_valid | out_ready) & (|eligible);
   assign quiescent = ~out_valid;
   assign next_ptr  = (grant == TAG_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : grant + TAG_WIDTH'(1);

   // Cyclic search from rr_ptr: lowest eligible at/above the pointer, else lowest overall.
   always_comb begin
      grant_hi = '0;
      grant_lo = '0;
      found_hi = 1'b0;
      for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            grant_lo = TAG_WIDTH'(i);
            if (TAG_WIDTH'(i) >= rr_ptr) begin
               grant_hi = TAG_WIDTH'(i);
               found_hi = 1'b1;
            end
         end
      end
      grant = found_hi ? grant_hi : grant_lo;
   end

   // Select the granted requester's word.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
         if (grant == TAG_WIDTH'(i)) begin
            sel_data = in_data[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   // One-hot accept strobe; held low while reset is asserted.
   always_comb begin
      in_ready = '0;
      if (load && reset) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Output register, round-robin pointer and transfer counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_tag        <= '0;
         rr_ptr         <= '0;
         transfer_count <= '0;
      end else begin
         if (drain) begin
            transfer_count <= transfer_count + COUNT_WIDTH'(1);
         end
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_tag   <= grant;
            rr_ptr    <= next_ptr;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: reference model + scoreboard at each negedge,
// plus directed scenarios checked one step after the active edge.
module tb_router_output_arbiter;

   localparam int N  = 4;
   localparam int WW = 32;
   localparam int CW = 16;
   localparam int TW = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic [N-1:0]    requester_mask = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N*WW-1:0] in_data = '0;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [WW-1:0]   out_data;
   logic [TW-1:0]   out_tag;
   logic            out_ready = 1'b0;
   logic [CW-1:0]   transfer_count;
   logic            quiescent;

   logic [N-1:0]    in_ready4;
   logic            out_valid4;
   logic [WW-1:0]   out_data4;
   logic [TW-1:0]   out_tag4;
   logic [3:0]      transfer_count4;
   logic            quiescent4;

   int n_checks = 0;
   int n_errors = 0;

   router_output_arbiter #(.NUM_REQUESTERS(N), .WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .requester_mask(requester_mask),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
      .transfer_count(transfer_count), .quiescent(quiescent));

   router_output_arbiter #(.NUM_REQUESTERS(N), .WORD_WIDTH(WW), .COUNT_WIDTH(4)) dut_cw4 (
      .clock(clock), .reset(reset), .enable(enable), .requester_mask(requester_mask),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4), .out_valid(out_valid4),
      .out_data(out_data4), .out_tag(out_tag4), .out_ready(out_ready),
      .transfer_count(transfer_count4), .quiescent(quiescent4));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] word(input int seed, input int idx);
      return WW'(seed * 256 + idx) ^ 32'hA500_0000;
   endfunction

   int cur_seed = 0;

   task automatic set_data(input int seed);
      cur_seed = seed;
      for (int i = 0; i < N; i++) in_data[i*WW +: WW] = word(seed, i);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference model: values represent DUT registers between edges.
   logic                m_rst_seen = 1'b0;
   logic                m_valid = 1'b0;
   int                  m_ptr = 0;
   logic [CW-1:0]       m_count = '0;
   logic [3:0]          m_count4 = '0;
   logic [TW+WW-1:0]    sb[$];

   always @(negedge clock) begin
      logic [N-1:0]     elig;
      logic [N-1:0]     exp_ready;
      logic             m_load;
      int               g;
      logic [TW+WW-1:0] item;
      if (!reset) begin
         check("rst_in_ready", 64'(in_ready), 64'(0));
         m_rst_seen = 1'b1;
         m_valid    = 1'b0;
         m_ptr      = 0;
         m_count    = '0;
         m_count4   = '0;
         sb.delete();
      end else if (m_rst_seen) begin
         check("out_valid", 64'(out_valid), 64'(m_valid));
         check("quiescent", 64'(quiescent), 64'(!m_valid));
         check("count", 64'(transfer_count), 64'(m_count));
         check("count_cw4", 64'(transfer_count4), 64'(m_count4));
         elig   = in_valid & requester_mask;
         m_load = enable && (!m_valid || out_ready) && (elig != '0);
         g = 0;
         for (int k = N - 1; k >= 0; k--) begin
            if (elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         exp_ready = '0;
         if (m_load) exp_ready[g] = 1'b1;
         check("in_ready", 64'(in_ready), 64'(exp_ready));
         if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", 64'(0), 64'(1));
            end else begin
               item = sb.pop_front();
               check("out_tag", 64'(out_tag), 64'(item[TW+WW-1:WW]));
               check("out_data", 64'(out_data), 64'(item[WW-1:0]));
            end
            m_count  = m_count + CW'(1);
            m_count4 = m_count4 + 4'(1);
         end
         if (m_load) begin
            sb.push_back({TW'(g), in_data[g*WW +: WW]});
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      logic [WW-1:0] held;
      set_data(1);
      repeat (3) step();
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_quiescent", 64'(quiescent), 64'(1));
      check("rst_count", 64'(transfer_count), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      reset = 1'b1;

      // Fairness: all requesting, always ready.
      enable = 1'b1; requester_mask = 4'hF; in_valid = 4'hF; out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         step();
         check("fair_tag", 64'(out_tag), 64'(j % 4));
         check("fair_data", 64'(out_data), 64'(word(cur_seed, j % 4)));
         check("fair_count", 64'(transfer_count), 64'(j));
         set_data(j + 2);
      end
      in_valid = '0;
      step();
      check("drain_valid", 64'(out_valid), 64'(0));
      check("drain_count", 64'(transfer_count), 64'(8));

      // Backpressure: single word held for 5 cycles.
      out_ready = 1'b0; in_valid = 4'b0100; set_data(20);
      step();
      check("bp_load_tag", 64'(out_tag), 64'(2));
      held = word(20, 2);
      in_valid = 4'hF; set_data(21);
      for (int j = 0; j < 5; j++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'(0));
         step();
         check("bp_valid", 64'(out_valid), 64'(1));
         check("bp_data", 64'(out_data), 64'(held));
         check("bp_tag", 64'(out_tag), 64'(2));
         check("bp_count", 64'(transfer_count), 64'(8));
      end
      out_ready = 1'b1; in_valid = '0;
      step();
      check("bp_release_count", 64'(transfer_count), 64'(9));

      // Masking with pointer wrap: pointer sits at 3.
      in_valid = 4'b1011; requester_mask = 4'b0011; set_data(30);
      #1;
      check("mask_ready0", 64'(in_ready), 64'(4'b0001));
      step();
      check("mask_tag0", 64'(out_tag), 64'(0));
      #1;
      check("mask_ready1", 64'(in_ready), 64'(4'b0010));
      step();
      check("mask_tag1", 64'(out_tag), 64'(1));
      check("mask_count", 64'(transfer_count), 64'(10));

      // Enable low: held word drains, no new grants.
      requester_mask = 4'hF; in_valid = 4'hF; out_ready = 1'b0; enable = 1'b0;
      #1;
      check("en_ready_stall", 64'(in_ready), 64'(0));
      repeat (2) step();
      check("en_held_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      #1;
      check("en_ready_drain", 64'(in_ready), 64'(0));
      step();
      check("en_quiescent", 64'(quiescent), 64'(1));
      check("en_count", 64'(transfer_count), 64'(11));

      // Mid-operation reset with a stalled word.
      enable = 1'b1; out_ready = 1'b0;
      step();
      check("mr_loaded_tag", 64'(out_tag), 64'(2));
      reset = 1'b0;
      #1;
      check("mr_in_ready", 64'(in_ready), 64'(0));
      step();
      check("mr_valid", 64'(out_valid), 64'(0));
      check("mr_count", 64'(transfer_count), 64'(0));
      check("mr_quiescent", 64'(quiescent), 64'(1));
      reset = 1'b1; out_ready = 1'b1;
      step();
      check("mr_ptr_tag", 64'(out_tag), 64'(0));

      // Counter wrap: 17 transfers.
      for (int j = 0; j < 17; j++) begin
         set_data(40 + j);
         step();
      end
      check("wrap_count4", 64'(transfer_count4), 64'(1));
      check("wrap_count16", 64'(transfer_count), 64'(17));

      // Random traffic against the model.
      for (int j = 0; j < 300; j++) begin
         enable         = ($urandom_range(0, 7) != 0);
         requester_mask = N'($urandom);
         in_valid       = N'($urandom);
         out_ready      = ($urandom_range(0, 3) != 0);
         set_data(100 + j);
         step();
      end

      enable = 1'b0; out_ready = 1'b1; in_valid = '0;
      repeat (3) step();
      check("end_quiescent", 64'(quiescent), 64'(1));
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
